// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared definitions for the SDRAM frame arbiter.
//   state_t       - burst scheduler FSM states
//   OP_RD / OP_WR - encoding of the controller rw bit
//   region_base() - first burst address of a (channel, bank) frame region
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI
  } state_t;

  localparam logic OP_RD = 1'b1;
  localparam logic OP_WR = 1'b0;

  // Each channel owns two consecutive frame regions (ping and pong).
  function automatic int unsigned region_base(input int unsigned ch,
                                              input int unsigned bank,
                                              input int unsigned frame_bursts);
    return (2 * ch + bank) * frame_bursts;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req   - request vector, one bit per source
//   last  - index of the most recently granted source; search starts after it
//   grant - one-hot grant (all zero when nothing requests)
//   valid - some source was granted
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last,
  output logic [N-1:0]  grant,
  output logic          valid
);

  int pos;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    pos   = 0;
    for (int off = 1; off <= N; off++) begin
      pos = (int'(last) + off) % N;
      if (!valid && req[pos[PW-1:0]]) begin
        grant[pos[PW-1:0]] = 1'b1;
        valid              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter: burst scheduler between NUM_CH producer FIFOs, a
// display FIFO and a full-page SDRAM controller. Each producer writes
// ping-pong frame buffers; the display reads the last completed frame of
// the selected channel.
//   clk, rst           - SDRAM clock, asynchronous active-high reset
//   ch_level/ch_data   - packed producer FIFO levels and show-ahead data
//   ch_rd              - producer FIFO read strobes
//   disp_sel           - requested display channel (taken at frame wrap)
//   disp_level         - display FIFO level; disp_push/disp_data feed it
//   ctl_*              - sdram_controller request / data handshake
//   frame_done         - one-cycle pulse per channel on frame completion
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 15,
  parameter int FRAME_BURSTS = 600,
  parameter int LVL_W        = 10,
  parameter int WR_THRESH    = 512,
  parameter int RD_LOW       = 250,
  parameter int RD_URGENT    = 64,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*LVL_W-1:0]  ch_level,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_rd,
  input  logic [CH_W-1:0]          disp_sel,
  input  logic [LVL_W-1:0]         disp_level,
  output logic                     disp_push,
  output logic [DATA_W-1:0]        disp_data,
  input  logic                     ctl_ready,
  output logic                     ctl_rw,
  output logic                     ctl_rw_en,
  output logic [ADDR_W-1:0]        ctl_addr,
  output logic [DATA_W-1:0]        ctl_wdata,
  input  logic                     ctl_wvalid,
  input  logic [DATA_W-1:0]        ctl_rdata,
  input  logic                     ctl_rvalid,
  output logic [NUM_CH-1:0]        frame_done
);

  localparam int IDX_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam int TAB_N = 2 ** (CH_W + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BURSTS - 1);

  if (2 * NUM_CH * FRAME_BURSTS > 2 ** ADDR_W) begin : g_addr_check
    $error("sdram_frame_arbiter: frame regions exceed the ADDR_W address space");
  end
  if (NUM_CH < 1 || NUM_CH > 4) begin : g_ch_check
    $error("sdram_frame_arbiter: NUM_CH must be 1..4");
  end

  state_t state, state_next;
  logic              op;
  logic [CH_W-1:0]   gch;
  logic [CH_W-1:0]   last_gnt;
  logic [IDX_W-1:0]  wr_idx [NUM_CH];
  logic [NUM_CH-1:0] wr_bank, done_bank, valid_frame, wr_req, rr_grant;
  logic              rr_valid;
  logic [CH_W-1:0]   rr_ch, rd_ch, sel;
  logic              rd_bank;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_urgent, rd_low, gnt, gnt_op, issue_wr, issue_rd;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  // Region bases indexed by {channel, bank}; constants, so the address
  // path is only a mux plus an adder.
  logic [ADDR_W-1:0] base_tab [TAB_N];
  for (genvar gi = 0; gi < TAB_N; gi++) begin : g_base
    if (gi < 2 * NUM_CH) begin : g_used
      assign base_tab[gi] = ADDR_W'(region_base(gi / 2, gi % 2, FRAME_BURSTS));
    end else begin : g_unused
      assign base_tab[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_req
    assign wr_req[gi] = ch_level[gi*LVL_W +: LVL_W] > LVL_W'(WR_THRESH);
  end

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .req   (wr_req),
    .last  (last_gnt),
    .grant (rr_grant),
    .valid (rr_valid)
  );

  always_comb begin
    rr_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rr_grant[i]) rr_ch = CH_W'(i);
    end
  end

  assign rd_urgent = valid_frame[rd_ch] && (disp_level < LVL_W'(RD_URGENT));
  assign rd_low    = valid_frame[rd_ch] && (disp_level < LVL_W'(RD_LOW));
  assign wr_addr   = base_tab[{rr_ch, wr_bank[rr_ch]}] + ADDR_W'(wr_idx[rr_ch]);
  assign rd_addr   = base_tab[{rd_ch, rd_bank}] + ADDR_W'(rd_idx);
  assign sel       = (int'(disp_sel) < NUM_CH) ? disp_sel : '0;
  assign issue_wr  = (state == S_ISSUE) && (op == OP_WR);
  assign issue_rd  = (state == S_ISSUE) && (op == OP_RD);

  // Urgent reads beat writes; ordinary reads only fill otherwise idle slots.
  always_comb begin
    gnt    = 1'b0;
    gnt_op = OP_WR;
    if (rd_urgent) begin
      gnt    = 1'b1;
      gnt_op = OP_RD;
    end else if (rr_valid) begin
      gnt    = 1'b1;
      gnt_op = OP_WR;
    end else if (rd_low) begin
      gnt    = 1'b1;
      gnt_op = OP_RD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ctl_rw_en  = 1'b0;
    ch_rd      = '0;
    case (state)
      S_IDLE:    if (ctl_ready) state_next = S_ARB;
      S_ARB:     if (gnt) state_next = S_ISSUE;
      S_ISSUE: begin
        ctl_rw_en  = 1'b1;
        state_next = S_WAIT_LO;
      end
      S_WAIT_LO, S_WAIT_HI: begin
        // Combinational pop so show-ahead data is ready for the next edge.
        if (ctl_wvalid && op == OP_WR) ch_rd[gch] = 1'b1;
        if (state == S_WAIT_LO && !ctl_ready) state_next = S_WAIT_HI;
        if (state == S_WAIT_HI && ctl_ready)  state_next = S_ARB;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // Grant registers: op, channel and the request presented during ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op       <= OP_WR;
      gch      <= '0;
      last_gnt <= CH_W'(NUM_CH - 1);
      ctl_rw   <= 1'b0;
      ctl_addr <= '0;
    end else if (state == S_ARB && gnt) begin
      op     <= gnt_op;
      ctl_rw <= gnt_op;
      if (gnt_op == OP_WR) begin
        gch      <= rr_ch;
        last_gnt <= rr_ch;
        ctl_addr <= wr_addr;
      end else begin
        ctl_addr <= rd_addr;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [IDX_W-1:0] idx;
    logic bank, dbank, vf, fd, hit;
    assign hit = issue_wr && (gch == CH_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        idx   <= '0;
        bank  <= 1'b0;
        dbank <= 1'b0;
        vf    <= 1'b0;
        fd    <= 1'b0;
      end else begin
        fd <= 1'b0;
        if (hit) begin
          if (idx == IDX_LAST) begin
            idx   <= '0;
            dbank <= bank;
            bank  <= ~bank;
            vf    <= 1'b1;
            fd    <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end
    end

    assign wr_idx[gi]      = idx;
    assign wr_bank[gi]     = bank;
    assign done_bank[gi]   = dbank;
    assign valid_frame[gi] = vf;
    assign frame_done[gi]  = fd;
  end

  // The display channel and bank are only re-chosen at the frame wrap, so
  // a whole frame is always read from one buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ch   <= '0;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
    end else if (issue_rd) begin
      if (rd_idx == IDX_LAST) begin
        rd_idx  <= '0;
        rd_ch   <= sel;
        rd_bank <= done_bank[sel];
      end else begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  assign ctl_wdata = ch_data[gch*DATA_W +: DATA_W];
  assign disp_push = ctl_rvalid && (op == OP_RD);
  assign disp_data = ctl_rdata;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// tb_sdram_frame_arbiter: directed bench for sdram_frame_arbiter with the
// default parameters. A behavioural controller answers each request.
module tb_sdram_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] ch_level;
  logic [31:0] ch_data;
  logic [1:0]  ch_rd;
  logic        disp_sel;
  logic [9:0]  disp_level;
  logic        disp_push;
  logic [15:0] disp_data;
  logic        ctl_ready, ctl_rw, ctl_rw_en;
  logic [14:0] ctl_addr;
  logic [15:0] ctl_wdata, ctl_rdata;
  logic        ctl_wvalid, ctl_rvalid;
  logic [1:0]  frame_done;

  int compares = 0;
  int fails    = 0;
  int fd0      = 0;
  int fd1      = 0;

  always #5 clk = ~clk;

  sdram_frame_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .ch_level   (ch_level),
    .ch_data    (ch_data),
    .ch_rd      (ch_rd),
    .disp_sel   (disp_sel),
    .disp_level (disp_level),
    .disp_push  (disp_push),
    .disp_data  (disp_data),
    .ctl_ready  (ctl_ready),
    .ctl_rw     (ctl_rw),
    .ctl_rw_en  (ctl_rw_en),
    .ctl_addr   (ctl_addr),
    .ctl_wdata  (ctl_wdata),
    .ctl_wvalid (ctl_wvalid),
    .ctl_rdata  (ctl_rdata),
    .ctl_rvalid (ctl_rvalid),
    .frame_done (frame_done)
  );

  always @(negedge clk) begin
    if (frame_done[0]) fd0++;
    if (frame_done[1]) fd1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Returns {rw, addr} of the next request, or 16'hFFFF if none within bound.
  task automatic get_issue(output logic [15:0] got);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ctl_rw_en !== 1'b1 && n < 200);
    if (ctl_rw_en === 1'b1) got = {ctl_rw, ctl_addr};
    else                    got = 16'hFFFF;
  endtask

  // Called at the ISSUE cycle: drops ready, streams n data beats, raises ready.
  task automatic burst(input logic is_wr, input int n, input logic [15:0] exp_wdata,
                       output int rd0, output int rd1, output int push, output int bad);
    rd0 = 0; rd1 = 0; push = 0; bad = 0;
    @(negedge clk);
    ctl_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ctl_rdata = 16'h5A00 + 16'(k);
      if (is_wr) ctl_wvalid = 1'b1;
      else       ctl_rvalid = 1'b1;
      #1;
      if (ch_rd[0]) rd0++;
      if (ch_rd[1]) rd1++;
      if (disp_push) push++;
      if (is_wr && ctl_wdata !== exp_wdata) bad++;
      if (!is_wr && disp_data !== ctl_rdata) bad++;
    end
    @(negedge clk);
    ctl_wvalid = 1'b0;
    ctl_rvalid = 1'b0;
    ctl_ready  = 1'b1;
  endtask

  initial begin
    logic [15:0] got;
    int r0, r1, p, b, bad, n;

    rst        = 1'b1;
    ch_level   = '0;
    ch_data    = {16'hB1B1, 16'hA0A0};
    disp_sel   = 1'b0;
    disp_level = 10'd1023;
    ctl_ready  = 1'b1;
    ctl_wvalid = 1'b0;
    ctl_rvalid = 1'b1;
    ctl_rdata  = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_rw_en", ctl_rw_en, 0);
    check("rst_rw", ctl_rw, 0);
    check("rst_addr", ctl_addr, 0);
    check("rst_ch_rd", ch_rd, 0);
    check("rst_push", disp_push, 0);
    check("rst_frame_done", frame_done, 0);
    ctl_rvalid = 1'b0;
    rst        = 1'b0;

    // T1: single producer above threshold, first burst at address 0.
    ch_level[9:0] = 10'd513;
    get_issue(got);
    check("t1_issue0", got, {1'b0, 15'd0});
    burst(1'b1, 512, 16'hA0A0, r0, r1, p, b);
    check("t1_ch_rd0", r0, 512);
    check("t1_ch_rd1", r1, 0);
    check("t1_wdata", b, 0);
    get_issue(got);
    check("t1_issue1", got, {1'b0, 15'd1});
    burst(1'b1, 1, 16'hA0A0, r0, r1, p, b);

    // T2: both channels eligible -> alternate, ch1 region at 1200.
    ch_level = {10'd600, 10'd600};
    get_issue(got);
    check("t2_ch1_a", got, {1'b0, 15'd1200});
    burst(1'b1, 2, 16'hB1B1, r0, r1, p, b);
    check("t2_ch1_rd", r1, 2);
    check("t2_ch1_rd0", r0, 0);
    check("t2_ch1_wdata", b, 0);
    get_issue(got);
    check("t2_ch0_a", got, {1'b0, 15'd2});
    burst(1'b1, 1, 16'hA0A0, r0, r1, p, b);
    get_issue(got);
    check("t2_ch1_b", got, {1'b0, 15'd1201});
    burst(1'b1, 1, 16'hB1B1, r0, r1, p, b);
    get_issue(got);
    check("t2_ch0_b", got, {1'b0, 15'd3});
    burst(1'b1, 1, 16'hA0A0, r0, r1, p, b);

    // T3: finish ch0 frame, then read it back from address 0.
    ch_level = {10'd0, 10'd600};
    bad = 0;
    for (int k = 4; k < 600; k++) begin
      get_issue(got);
      if (got !== 16'(k)) bad++;
      burst(1'b1, 1, 16'hA0A0, r0, r1, p, b);
    end
    check("t3_frame_addrs", bad, 0);
    check("t3_fd0", fd0, 1);
    check("t3_fd1", fd1, 0);
    get_issue(got);
    check("t3_bank1", got, {1'b0, 15'd600});
    burst(1'b1, 1, 16'hA0A0, r0, r1, p, b);
    ch_level   = '0;
    disp_level = 10'd200;
    get_issue(got);
    check("t3_rd0", got, {1'b1, 15'd0});
    burst(1'b0, 3, 16'h0000, r0, r1, p, b);
    check("t3_push", p, 3);
    check("t3_rd_no_chrd", r0, 0);
    check("t3_rdata", b, 0);
    get_issue(got);
    check("t3_rd1", got, {1'b1, 15'd1});
    burst(1'b0, 1, 16'h0000, r0, r1, p, b);

    // T4: urgent read pre-empts a write; a non-urgent read does not.
    disp_level    = 10'd50;
    ch_level[9:0] = 10'd600;
    get_issue(got);
    check("t4_urgent_rd", got, {1'b1, 15'd2});
    burst(1'b0, 1, 16'h0000, r0, r1, p, b);
    disp_level = 10'd200;
    get_issue(got);
    check("t4_wr_first", got, {1'b0, 15'd601});
    burst(1'b1, 1, 16'hA0A0, r0, r1, p, b);
    ch_level = '0;
    get_issue(got);
    check("t4_low_rd", got, {1'b1, 15'd3});
    burst(1'b0, 1, 16'h0000, r0, r1, p, b);

    // T5: complete a ch1 frame, switch display mid-frame, switch at wrap.
    disp_level = 10'd1023;
    ch_level   = {10'd600, 10'd0};
    bad = 0;
    for (int k = 2; k < 600; k++) begin
      get_issue(got);
      if (got !== 16'(1200 + k)) bad++;
      burst(1'b1, 1, 16'hB1B1, r0, r1, p, b);
    end
    check("t5_ch1_frame_addrs", bad, 0);
    check("t5_fd1", fd1, 1);
    ch_level   = '0;
    disp_level = 10'd200;
    bad = 0;
    for (int k = 4; k < 600; k++) begin
      if (k == 300) disp_sel = 1'b1;
      get_issue(got);
      if (got !== (16'h8000 | 16'(k))) bad++;
      burst(1'b0, 1, 16'h0000, r0, r1, p, b);
    end
    check("t5_rd_ch0_addrs", bad, 0);
    get_issue(got);
    check("t5_rd_ch1_base", got, {1'b1, 15'd1200});
    burst(1'b0, 1, 16'h0000, r0, r1, p, b);
    get_issue(got);
    check("t5_rd_ch1_next", got, {1'b1, 15'd1201});
    burst(1'b0, 1, 16'h0000, r0, r1, p, b);

    // T6: reset during WAIT_HI of a write.
    disp_level    = 10'd1023;
    ch_level[9:0] = 10'd600;
    get_issue(got);
    check("t6_issue", got, {1'b0, 15'd602});
    @(negedge clk);
    ctl_ready = 1'b0;
    @(negedge clk);
    ctl_wvalid = 1'b1;
    #1;
    check("t6_pre_rst_ch_rd", ch_rd, 2'b01);
    rst = 1'b1;
    #1;
    check("t6_ch_rd", ch_rd, 0);
    check("t6_rw_en", ctl_rw_en, 0);
    check("t6_rw", ctl_rw, 0);
    check("t6_addr", ctl_addr, 0);
    check("t6_push", disp_push, 0);
    check("t6_frame_done", frame_done, 0);
    @(negedge clk);
    rst        = 1'b0;
    ctl_wvalid = 1'b0;
    ctl_ready  = 1'b1;
    ch_level   = '0;
    disp_level = 10'd50;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (ctl_rw_en === 1'b1) n++;
    end
    check("t6_no_read", n, 0);
    ch_level[9:0] = 10'd600;
    get_issue(got);
    check("t6_wr_restart", got, {1'b0, 15'd0});
    burst(1'b1, 1, 16'hA0A0, r0, r1, p, b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
